tile_map_arbiter: RTL and testbench

- Shares the single-port level tile RAM among three kinds of client:
  - the VGA background renderer;
  - a map-update writer, e.g. block break;
  - N collision-probe requesters: player motion logic plus enemy movers.
- The tile map is 15 rows x 20 columns of 2-bit tiles (32x32 px each); tile 2'b00 is solid ground, 2'b11 is sky.
- Grants one RAM access per clock with fixed priority renderer > writer > probes. Probes are served round-robin among themselves.
- Returns read data with a fixed, tagged latency.

---
 rtl/tile_map_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tile_map_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
// Arbitrates the single-port tile RAM between the renderer, the map writer and
// N collision probes, returning tagged read data a fixed number of clocks later.
module tile_map_arbiter #(
    parameter int         N_REQ           = 4,
    parameter int         RD_LAT          = 1,
    parameter logic [1:0] OOB_PROBE_TILE  = 2'b00,
    parameter logic [1:0] OOB_RENDER_TILE = 2'b11
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               render_req,
    input  logic [3:0]         render_row,
    input  logic [4:0]         render_col,
    output logic               render_valid,
    output logic [1:0]         render_tile,
    input  logic               wr_req,
    input  logic [3:0]         wr_row,
    input  logic [4:0]         wr_col,
    input  logic [1:0]         wr_tile,
    output logic               wr_ack,
    input  logic [N_REQ-1:0]   probe_req,
    input  logic [4*N_REQ-1:0] probe_row,
    input  logic [5*N_REQ-1:0] probe_col,
    output logic [N_REQ-1:0]   probe_gnt,
    output logic [N_REQ-1:0]   probe_rsp_valid,
    output logic [1:0]         probe_rsp_tile,
    output logic [8:0]         ram_addr,
    output logic               ram_we,
    output logic [1:0]         ram_wdata,
    input  logic [1:0]         ram_rdata
);

    localparam int IDX_W = 3;

    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_RENDER = 2'd1;
    localparam logic [1:0] KIND_PROBE  = 2'd2;

    typedef struct packed {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
        logic             oob;
        logic [1:0]       tile;
    } rsp_t;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] probe_sel;
    logic             probe_found;
    logic [3:0]       probe_sel_row;
    logic [4:0]       probe_sel_col;

    logic             do_render;
    logic             do_write;
    logic             do_probe;
    logic             issue_oob;
    logic [3:0]       issue_row;
    logic [4:0]       issue_col;
    logic [8:0]       issue_addr;
    rsp_t             issue_rsp;

    rsp_t             rsp_pipe [RD_LAT+1];
    rsp_t             rsp_head;
    logic [1:0]       rsp_data;

    // Two descending passes: the first finds the lowest requester at or above
    // rr_ptr, the second wraps around to the lowest requester overall.
    always_comb begin
        probe_found   = 1'b0;
        probe_sel     = '0;
        probe_sel_row = '0;
        probe_sel_col = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (probe_req[i] && (i >= int'(rr_ptr))) begin
                probe_found   = 1'b1;
                probe_sel     = IDX_W'(i);
                probe_sel_row = probe_row[4*i +: 4];
                probe_sel_col = probe_col[5*i +: 5];
            end
        end
        if (!probe_found) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (probe_req[i]) begin
                    probe_found   = 1'b1;
                    probe_sel     = IDX_W'(i);
                    probe_sel_row = probe_row[4*i +: 4];
                    probe_sel_col = probe_col[5*i +: 5];
                end
            end
        end
    end

    always_comb begin
        do_render = render_req;
        do_write  = !render_req && wr_req;
        do_probe  = !render_req && !wr_req && probe_found;
        issue_row = '0;
        issue_col = '0;
        if (do_render) begin
            issue_row = render_row;
            issue_col = render_col;
        end else if (do_write) begin
            issue_row = wr_row;
            issue_col = wr_col;
        end else if (do_probe) begin
            issue_row = probe_sel_row;
            issue_col = probe_sel_col;
        end
        issue_oob  = (issue_row >= 4'd15) || (issue_col >= 5'd20);
        issue_addr = ({5'd0, issue_row} << 4) + ({5'd0, issue_row} << 2) + {4'd0, issue_col};
        issue_rsp  = '0;
        if (do_render) begin
            issue_rsp.kind = KIND_RENDER;
            issue_rsp.oob  = issue_oob;
            issue_rsp.tile = OOB_RENDER_TILE;
        end else if (do_probe) begin
            issue_rsp.kind = KIND_PROBE;
            issue_rsp.idx  = probe_sel;
            issue_rsp.oob  = issue_oob;
            issue_rsp.tile = OOB_PROBE_TILE;
        end
    end

    // Out-of-range accesses still consume the slot but leave the RAM address alone.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rr_ptr    <= '0;
            wr_ack    <= 1'b0;
            probe_gnt <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                rsp_pipe[k] <= '0;
            end
        end else begin
            wr_ack    <= do_write;
            probe_gnt <= do_probe ? (N_REQ'(1) << probe_sel) : '0;
            ram_we    <= do_write && !issue_oob;
            if ((do_render || do_write || do_probe) && !issue_oob) begin
                ram_addr <= issue_addr;
            end
            if (do_write && !issue_oob) begin
                ram_wdata <= wr_tile;
            end
            if (do_probe) begin
                rr_ptr <= (probe_sel == IDX_W'(N_REQ - 1)) ? '0 : probe_sel + 1'b1;
            end
            rsp_pipe[0] <= issue_rsp;
            for (int k = 1; k <= RD_LAT; k++) begin
                rsp_pipe[k] <= rsp_pipe[k-1];
            end
        end
    end

    assign rsp_head        = rsp_pipe[RD_LAT];
    assign rsp_data        = rsp_head.oob ? rsp_head.tile : ram_rdata;
    assign render_valid    = (rsp_head.kind == KIND_RENDER);
    assign render_tile     = render_valid ? rsp_data : 2'b00;
    assign probe_rsp_valid = (rsp_head.kind == KIND_PROBE) ? (N_REQ'(1) << rsp_head.idx) : '0;
    assign probe_rsp_tile  = (rsp_head.kind == KIND_PROBE) ? rsp_data : 2'b00;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Randomised bench for tile_map_arbiter: a map-level reference model predicts every
// grant, ack, RAM strobe and tagged response; a behavioural RAM sits behind the DUT.
module tb_tile_map_arbiter;

    localparam int         N_REQ    = 4;
    localparam int         RD_LAT   = 3;
    localparam logic [1:0] OOB_P    = 2'b00;
    localparam logic [1:0] OOB_R    = 2'b11;

    logic               Clk = 1'b0;
    logic               Reset_n = 1'b0;
    logic               render_req = 1'b0;
    logic [3:0]         render_row = '0;
    logic [4:0]         render_col = '0;
    logic               render_valid;
    logic [1:0]         render_tile;
    logic               wr_req = 1'b0;
    logic [3:0]         wr_row = '0;
    logic [4:0]         wr_col = '0;
    logic [1:0]         wr_tile = '0;
    logic               wr_ack;
    logic [N_REQ-1:0]   probe_req = '0;
    logic [4*N_REQ-1:0] probe_row = '0;
    logic [5*N_REQ-1:0] probe_col = '0;
    logic [N_REQ-1:0]   probe_gnt;
    logic [N_REQ-1:0]   probe_rsp_valid;
    logic [1:0]         probe_rsp_tile;
    logic [8:0]         ram_addr;
    logic               ram_we;
    logic [1:0]         ram_wdata;
    logic [1:0]         ram_rdata;

    tile_map_arbiter #(
        .N_REQ(N_REQ), .RD_LAT(RD_LAT), .OOB_PROBE_TILE(OOB_P), .OOB_RENDER_TILE(OOB_R)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .render_req(render_req), .render_row(render_row), .render_col(render_col),
        .render_valid(render_valid), .render_tile(render_tile),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_tile(wr_tile), .wr_ack(wr_ack),
        .probe_req(probe_req), .probe_row(probe_row), .probe_col(probe_col),
        .probe_gnt(probe_gnt), .probe_rsp_valid(probe_rsp_valid), .probe_rsp_tile(probe_rsp_tile),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    // Single-port RAM with RD_LAT read latency; loads its initial image on the first edge.
    logic [1:0] init_mem [0:299];
    logic [1:0] mem [0:299];
    logic [1:0] rd_pipe [0:RD_LAT-1];
    bit         mem_loaded;

    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 300; i++) mem[i] <= init_mem[i];
            mem_loaded <= 1'b1;
        end else if (ram_we && ram_addr < 9'd300) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_pipe[0] <= (ram_addr < 9'd300) ? mem[ram_addr] : 2'b00;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    typedef struct {
        int         due;
        int         kind;
        int         idx;
        logic [1:0] tile;
    } exp_rsp_t;

    logic [1:0] map_model [0:14][0:19];
    exp_rsp_t   rsp_q[$];
    int         rr_model = 0;
    int         cycle = 0;
    logic [8:0] addr_model = '0;
    int         last_kind = 0;
    int         last_idx = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
        end
    endtask

    // Predicts one issue slot from the current inputs, clocks once, then checks.
    task automatic applyStimulus();
        int         kind, idx, row, col;
        bit         oob, hit;
        logic [1:0] wdata_exp;
        logic [1:0] tile;
        exp_rsp_t   r;
        bit         exp_rv;
        logic [N_REQ-1:0] exp_pv;
        logic [1:0] exp_tile;
        kind = 0; idx = 0; row = 0; col = 0; hit = 0;
        wdata_exp = wr_tile;
        if (render_req) begin
            kind = 1; row = int'(render_row); col = int'(render_col);
        end else if (wr_req) begin
            kind = 2; row = int'(wr_row); col = int'(wr_col);
        end else if (probe_req != '0) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!hit && probe_req[(rr_model + k) % N_REQ]) begin
                    hit = 1; idx = (rr_model + k) % N_REQ;
                end
            end
            kind = 3;
            row = int'(probe_row[4*idx +: 4]);
            col = int'(probe_col[5*idx +: 5]);
        end
        oob = (row >= 15) || (col >= 20);
        if (kind == 2 && !oob) map_model[row][col] = wdata_exp;
        if (kind != 0 && !oob) addr_model = 9'(row * 20 + col);
        if (kind == 1 || kind == 3) begin
            tile = oob ? ((kind == 1) ? OOB_R : OOB_P) : map_model[row][col];
            rsp_q.push_back('{cycle + 1 + RD_LAT, kind, idx, tile});
        end
        if (kind == 3) rr_model = (idx + 1) % N_REQ;

        @(posedge Clk);
        cycle++;
        #1;
        checkOutput("wr_ack", 32'(wr_ack), 32'(kind == 2));
        checkOutput("probe_gnt", 32'(probe_gnt), (kind == 3) ? (32'd1 << idx) : 32'd0);
        checkOutput("ram_we", 32'(ram_we), 32'(kind == 2 && !oob));
        checkOutput("ram_addr", 32'(ram_addr), 32'(addr_model));
        if (kind == 2 && !oob) checkOutput("ram_wdata", 32'(ram_wdata), 32'(wdata_exp));

        exp_rv = 0; exp_pv = '0; exp_tile = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cycle) begin
            r = rsp_q.pop_front();
            exp_tile = r.tile;
            if (r.kind == 1) exp_rv = 1;
            else exp_pv = N_REQ'(1) << r.idx;
        end
        checkOutput("render_valid", 32'(render_valid), 32'(exp_rv));
        checkOutput("probe_rsp_valid", 32'(probe_rsp_valid), 32'(exp_pv));
        if (exp_rv) checkOutput("render_tile", 32'(render_tile), 32'(exp_tile));
        if (exp_pv != '0) checkOutput("probe_rsp_tile", 32'(probe_rsp_tile), 32'(exp_tile));
        last_kind = kind;
        last_idx = idx;
    endtask

    task automatic newProbe(input int i);
        probe_row[4*i +: 4] = 4'($urandom_range(0, 15));
        probe_col[5*i +: 5] = 5'($urandom_range(0, 23));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_render_valid"}, 32'(render_valid), 0);
        checkOutput({tag, "_render_tile"}, 32'(render_tile), 0);
        checkOutput({tag, "_wr_ack"}, 32'(wr_ack), 0);
        checkOutput({tag, "_probe_gnt"}, 32'(probe_gnt), 0);
        checkOutput({tag, "_probe_rsp_valid"}, 32'(probe_rsp_valid), 0);
        checkOutput({tag, "_probe_rsp_tile"}, 32'(probe_rsp_tile), 0);
        checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 0);
        checkOutput({tag, "_ram_we"}, 32'(ram_we), 0);
        checkOutput({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    endtask

    int gseq [5] = '{1, 2, 4, 8, 1};

    initial begin
        logic [1:0] t;
        for (int i = 0; i < 300; i++) begin
            t = 2'($urandom);
            if (i == 216) t = 2'b00;
            init_mem[i] = t;
            map_model[i / 20][i % 20] = t;
        end

        repeat (2) @(posedge Clk);
        #1;
        checkAllZero("reset");
        Reset_n = 1'b1;

        // Render read at (10,16)
        render_req = 1'b1; render_row = 4'd10; render_col = 5'd16;
        applyStimulus();
        checkOutput("t1_addr", 32'(ram_addr), 216);
        render_req = 1'b0;
        repeat (RD_LAT) applyStimulus();

        // All four probes held: round-robin rotation
        probe_req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin
            probe_row[4*i +: 4] = 4'd3; probe_col[5*i +: 5] = 5'd4;
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus();
            checkOutput("t2_gnt_seq", 32'(probe_gnt), gseq[k]);
        end
        probe_req = '0;
        repeat (RD_LAT) applyStimulus();

        // Renderer starves writer and probe for five cycles
        render_req = 1'b1; render_row = 4'd1; render_col = 5'd1;
        wr_req = 1'b1; wr_row = 4'd5; wr_col = 5'd5; wr_tile = 2'b10;
        probe_req = 4'b0100;
        repeat (5) applyStimulus();
        render_req = 1'b0;
        applyStimulus();
        checkOutput("t3_wr_ack", 32'(wr_ack), 1);
        checkOutput("t3_ram_we", 32'(ram_we), 1);
        wr_req = 1'b0;
        applyStimulus();
        checkOutput("t3_gnt", 32'(probe_gnt), 32'b0100);
        probe_req = '0;
        repeat (RD_LAT) applyStimulus();

        // Write then probe the same tile
        wr_req = 1'b1; wr_row = 4'd9; wr_col = 5'd17; wr_tile = 2'b11;
        applyStimulus();
        wr_req = 1'b0;
        probe_req = 4'b0001; probe_row[3:0] = 4'd9; probe_col[4:0] = 5'd17;
        applyStimulus();
        checkOutput("t4_gnt", 32'(probe_gnt), 1);
        probe_req = '0;
        repeat (RD_LAT) applyStimulus();
        checkOutput("t4_rsp_valid", 32'(probe_rsp_valid), 1);
        checkOutput("t4_rsp_tile", 32'(probe_rsp_tile), 32'b11);

        // Out-of-range probe, render and write
        probe_req = 4'b0001; probe_row[3:0] = 4'd15; probe_col[4:0] = 5'd3;
        applyStimulus();
        probe_req = '0;
        render_req = 1'b1; render_row = 4'd2; render_col = 5'd20;
        applyStimulus();
        render_req = 1'b0;
        repeat (RD_LAT - 1) applyStimulus();
        checkOutput("t5_probe_valid", 32'(probe_rsp_valid), 1);
        checkOutput("t5_probe_tile", 32'(probe_rsp_tile), 32'(OOB_P));
        applyStimulus();
        checkOutput("t5_render_valid", 32'(render_valid), 1);
        checkOutput("t5_render_tile", 32'(render_tile), 32'(OOB_R));
        wr_req = 1'b1; wr_row = 4'd14; wr_col = 5'd25; wr_tile = 2'b01;
        applyStimulus();
        checkOutput("t5_oob_ack", 32'(wr_ack), 1);
        checkOutput("t5_oob_we", 32'(ram_we), 0);
        wr_req = 1'b0;

        // Randomised traffic honouring the hold-until-grant handshake
        for (int n = 0; n < 600; n++) begin
            render_req = ($urandom_range(0, 3) == 0);
            render_row = 4'($urandom_range(0, 15));
            render_col = 5'($urandom_range(0, 23));
            if (!wr_req || last_kind == 2) begin
                wr_req = ($urandom_range(0, 3) == 0);
                wr_row = 4'($urandom_range(0, 15));
                wr_col = 5'($urandom_range(0, 23));
                wr_tile = 2'($urandom);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!probe_req[i] || (last_kind == 3 && last_idx == i)) begin
                    probe_req[i] = 1'($urandom_range(0, 1));
                    newProbe(i);
                end
            end
            applyStimulus();
        end

        // Reset while probe reads are in flight
        render_req = 1'b0; wr_req = 1'b0; probe_req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) begin
            probe_row[4*i +: 4] = 4'($urandom_range(0, 14));
            probe_col[5*i +: 5] = 5'($urandom_range(0, 19));
        end
        repeat (2) applyStimulus();
        #2 Reset_n = 1'b0;
        #1 checkAllZero("t6_reset");
        @(posedge Clk);
        cycle++;
        #1;
        rsp_q.delete();
        rr_model = 0;
        addr_model = '0;
        Reset_n = 1'b1;
        probe_req = 4'b1010;
        applyStimulus();
        checkOutput("t6_first_gnt", 32'(probe_gnt), 32'b0010);
        probe_req = '0;
        repeat (RD_LAT + 2) applyStimulus();
        checkOutput("rsp_drain", 32'(rsp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
